// File: rtl/tinyproc_pkg.sv
// Shared defaults and state encoding for the tinyproc data-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tinyproc_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  // CLEAR sweeps zeros through the RAM after reset; RUN serves the two ports.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_t;

endpackage

// File: rtl/tinyproc_data_ram.sv
// Data RAM: one write port, one synchronous read port.
// Latency: read data appears one cycle after re; writes land on the same edge.
// Backpressure: none, every enabled access completes.
module tinyproc_data_ram
  import tinyproc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Write and registered read; contents need no reset since the owner clears them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/tinyproc_mem_arbiter.sv
// Two-port arbiter in front of the data RAM, with a post-reset clear sweep.
// Latency: grant is combinational; read data valid one cycle after grant.
// Backpressure: ungranted requesters must hold their request; nothing is queued.
module tinyproc_mem_arbiter
  import tinyproc_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ROUND_ROBIN = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              busy,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1
);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              last_q;      // 1 = port 1 was granted most recently
  logic              rv0_q, rv1_q;
  logic [DATA_W-1:0] hold0_q, hold1_q;

  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  // Next state, busy and grants. Grants are masked while reset is low so a
  // reset cycle never performs an access.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy = 1'b1;
        if (&clr_cnt_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (req0 && req1) begin
          // Round robin hands the conflict to whoever did not win last time.
          if (ROUND_ROBIN != 0 && !last_q) begin
            gnt1 = 1'b1;
          end else begin
            gnt0 = 1'b1;
          end
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
    endcase
    if (!reset_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  // RAM port steering: the clear sweep owns the write port while in CLEAR.
  always_comb begin
    ram_we    = (gnt0 && we0) || (gnt1 && we1);
    ram_waddr = gnt1 ? addr1 : addr0;
    ram_wdata = gnt1 ? wdata1 : wdata0;
    if (state_q == ST_CLEAR) begin
      ram_we    = reset_n;
      ram_waddr = clr_cnt_q;
      ram_wdata = '0;
    end
    ram_re    = (gnt0 && !we0) || (gnt1 && !we1);
    ram_raddr = gnt1 ? addr1 : addr0;
  end

  // FSM, clear counter, last winner and read-valid flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      last_q    <= 1'b1;
      rv0_q     <= 1'b0;
      rv1_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      // Counter wraps back to zero as the sweep finishes.
      if (state_q == ST_CLEAR) begin
        clr_cnt_q <= clr_cnt_q + 1'b1;
      end
      if (gnt0) begin
        last_q <= 1'b0;
      end else if (gnt1) begin
        last_q <= 1'b1;
      end
      rv0_q <= gnt0 && !we0;
      rv1_q <= gnt1 && !we1;
    end
  end

  // Capture delivered read data so rdata holds while rvalid is low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold0_q <= '0;
      hold1_q <= '0;
    end else begin
      if (rv0_q) begin
        hold0_q <= ram_rdata;
      end
      if (rv1_q) begin
        hold1_q <= ram_rdata;
      end
    end
  end

  assign rvalid0 = rv0_q;
  assign rvalid1 = rv1_q;
  assign rdata0  = rv0_q ? ram_rdata : hold0_q;
  assign rdata1  = rv1_q ? ram_rdata : hold1_q;

  tinyproc_data_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule
